// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_controller
//  Brief    : Instruction-fetch sequencer. Owns the PC, reads a combinational
//             instruction memory and queues {pc, instr} pairs in a small
//             fetch buffer presented to decode over valid/ready. EX-stage
//             redirects flush the buffer and reload the PC.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_controller #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          BUF_DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           run,
   output logic [31:0]                    imem_addr,
   input  logic [31:0]                    imem_rdata,
   input  logic                           redirect_valid,
   input  logic [31:0]                    redirect_pc,
   output logic                           if_valid,
   output logic [31:0]                    if_instr,
   output logic [31:0]                    if_pc,
   input  logic                           id_ready,
   output logic [$clog2(BUF_DEPTH):0]     buf_count
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] c_FULL_COUNT = CW'(BUF_DEPTH);

   logic [31:0]   pc_q;
   logic [31:0]   pc_d;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] rd_ptr_d;
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] wr_ptr_d;

   // Buffer payload: plain registers, never reset; visibility is gated by count.
   logic [31:0]   buf_pc_q    [BUF_DEPTH];
   logic [31:0]   buf_instr_q [BUF_DEPTH];

   logic w_not_empty;
   logic w_full;
   logic w_pop;
   logic w_fetch_fire;

   assign w_not_empty  = (count_q != '0);
   assign w_full       = (count_q == c_FULL_COUNT);
   // A redirect hides the head so decode can never consume a squashed entry.
   assign if_valid     = w_not_empty & ~redirect_valid;
   assign w_pop        = if_valid & id_ready;
   // A full buffer that is popping this cycle can still accept a fetch.
   assign w_fetch_fire = run & ~redirect_valid & (~w_full | w_pop);

   assign imem_addr = pc_q;
   assign if_pc     = if_valid ? buf_pc_q[rd_ptr_q]    : 32'h0;
   assign if_instr  = if_valid ? buf_instr_q[rd_ptr_q] : NOP_INSTR;
   assign buf_count = count_q;

   // Next-state for PC, occupancy and pointers; redirect overrides everything.
   always_comb begin
      pc_d     = pc_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (redirect_valid) begin
         pc_d     = {redirect_pc[31:2], 2'b00};
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (w_fetch_fire) begin
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + {{(CW-1){1'b0}}, w_fetch_fire}
                           - {{(CW-1){1'b0}}, w_pop};
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         pc_q     <= pc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Capture the fetched {pc, instr} pair into the slot at the write pointer.
   always_ff @(posedge clk) begin
      if (w_fetch_fire) begin
         buf_pc_q[wr_ptr_q]    <= pc_q;
         buf_instr_q[wr_ptr_q] <= imem_rdata;
      end
   end

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Instruction-fetch sequencer for the 5-stage pipeline. Owns the program counter, drives the combinational-read instruction memory every cycle, and captures {pc, instruction} pairs into a small fetch buffer. It presents them to decode over a valid/ready handshake. Branch/jump redirects from EX flush the buffer and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on if_instr when buffer empty (addi x0,x0,0)
BUF_DEPTH, 2, fetch-buffer entries (power of two, >=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
run  input  1  fetch enable; low = stop issuing new fetches, buffer keeps draining
imem_addr  output  32  address to instruction memory (= pc_q, combinational)
imem_rdata  input  32  instruction returned combinationally for imem_addr
redirect_valid  input  1  EX-stage taken branch/jump this cycle
redirect_pc  input  32  redirect target
if_valid  output  1  buffer head valid toward decode
if_instr  output  32  buffer head instruction (NOP_INSTR when !if_valid)
if_pc  output  32  buffer head PC (32'h0 when !if_valid)
id_ready  input  1  decode accepts head this cycle (low = pipeline stall)
buf_count  output  $clog2(BUF_DEPTH)+1  current occupancy, for debug/perf

Behaviour:
- Reset (rst_n low at posedge): pc_q<=RESET_PC; count, rd/wr pointers <=0. Outputs after reset: if_valid=0, if_instr=NOP_INSTR, if_pc=0, buf_count=0, imem_addr=RESET_PC. Reset mid-operation discards all buffered entries and any pending redirect.
- pop = if_valid & id_ready.
- fetch_fire = run & !redirect_valid & (count<BUF_DEPTH | pop). Full buffer plus simultaneous pop = fetch allowed (no bubble).
- On fetch_fire: push {pc_q, imem_rdata} at wr pointer; pc_q<=pc_q+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- count next = count + fetch_fire - pop. Pointers wrap mod BUF_DEPTH.
- Full (count==BUF_DEPTH) with no pop: no fetch, pc_q holds, imem_addr holds.
- Empty: if_valid=0 and outputs take the empty values above; pop impossible.
- Redirect has the highest priority:
  - if_valid is forced 0 combinationally in the redirect cycle, so no pop occurs.
  - At the edge: count<=0, pointers<=0, pc_q<={redirect_pc[31:2],2'b00}. Low two bits are ignored and no misalign trap is raised.
  - No fetch or push occurs that cycle, regardless of run or id_ready.
- Latency:
  - The PC presented in cycle N appears at the head in N+1 if the buffer was empty.
  - Redirect asserted in cycle N: target fetched in N+1, if_valid=1 with if_pc=target in N+2. Redirect penalty is two bubbles from the redirect cycle.
- run low: pc_q holds and the buffer drains normally. When run rises, fetching resumes from the held pc_q. A redirect while run is low still flushes and loads the PC.
- Back-to-back redirects: the last one wins, and each one flushes.
- Decode stall (id_ready low) with a non-empty buffer: head outputs stay stable until popped (handshake hold rule); buffered entries are never reordered or dropped.
- Buffer storage is plain registers, not reset (only count/pointers reset); outputs are gated by if_valid.

Test Plan:
- Reset then run=1, id_ready=1, memory holding 00500093, 00A00113, 002081B3 at 0,4,8 -> first if_valid at 2nd cycle after reset release with if_pc=0, if_instr=00500093, then pc 4 (00A00113), pc 8 (002081B3) on consecutive cycles, no bubbles.
- id_ready=0 for 5 cycles after the first valid -> buf_count rises to 2 and holds, imem_addr frozen at 8, if_pc=0 stable; id_ready=1 -> pcs 0,4,8,12 delivered on consecutive cycles, none lost or duplicated.
- Redirect with redirect_pc=32'h0000_0022 while buffer full -> that cycle if_valid=0; next cycle buf_count=0, imem_addr=32'h20; following cycle if_valid=1, if_pc=32'h20.
- Redirect and id_ready=1 and full buffer in the same cycle -> no pop counted, buffer flushed, next head is the redirect target only.
- run=0 with 2 entries buffered -> two pops occur, then if_valid=0 and if_instr=00000013, imem_addr constant; run=1 -> fetch resumes from the held PC.
- Redirect to 32'hFFFF_FFFC, run continuous -> if_pc sequence FFFF_FFFC, 0000_0000, 0000_0004; rst_n low mid-stream with a full buffer -> next cycle if_valid=0, buf_count=0, imem_addr=RESET_PC.
